// File: rtl/food_spawner.sv
// Food placement: samples random grid cells, confirms each with the body store, places food.
// Optional macro FOOD_SCORE_EN adds a saturating 8-bit score of eaten pulses.
module food_spawner #(
   parameter int MAX_TRIES = 8,
   parameter int X_MIN     = 10,
   parameter int X_MAX     = 620,
   parameter int Y_MIN     = 10,
   parameter int Y_MAX     = 460
) (
   input  logic       VGA_clk,
   input  logic       rst_n,
   input  logic [9:0] randX,
   input  logic [8:0] randY,
   input  logic       spawn_req,
   input  logic [9:0] head_x,
   input  logic [8:0] head_y,
   input  logic       head_upd,
   output logic       occ_req,
   output logic [9:0] occ_x,
   output logic [8:0] occ_y,
   input  logic       occ_ack,
   input  logic       occ_hit,
   output logic [9:0] food_x,
   output logic [8:0] food_y,
   output logic       food_valid,
   output logic       eaten,
   output logic       spawn_fail,
   output logic       busy
`ifdef FOOD_SCORE_EN
   , output logic [7:0] score
`endif
);

   typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, PLACED} state_t;

   localparam logic [9:0] XMIN_V  = X_MIN[9:0];
   localparam logic [9:0] XMAX_V  = X_MAX[9:0];
   localparam logic [8:0] YMIN_V  = Y_MIN[8:0];
   localparam logic [8:0] YMAX_V  = Y_MAX[8:0];
   localparam logic [3:0] TRY_LIM = MAX_TRIES[3:0];

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_try;
   logic [9:0] r_occ_x;
   logic [8:0] r_occ_y;
   logic [9:0] r_food_x;
   logic [8:0] r_food_y;
   logic       r_food_valid;
   logic       r_eaten;
   logic       r_fail;

   logic [3:0] w_try_nxt;
   logic       w_try_last;
   logic       w_legal;
   logic       w_start;
   logic       w_inc_try;
   logic       w_fail;
   logic       w_place;
   logic       w_eat;
   logic       w_load_occ;

   function automatic logic legal_x(input logic [9:0] x);
      return (x >= XMIN_V) && (x <= XMAX_V) && ((x % 10'd10) == 10'd0);
   endfunction

   function automatic logic legal_y(input logic [8:0] y);
      return (y >= YMIN_V) && (y <= YMAX_V) && ((y % 9'd10) == 9'd0);
   endfunction

   assign w_legal    = legal_x(randX) && legal_y(randY);
   assign w_try_nxt  = r_try + 4'd1;
   assign w_try_last = (w_try_nxt == TRY_LIM);

   always_ff @(posedge VGA_clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_inc_try  = 1'b0;
      w_fail     = 1'b0;
      w_place    = 1'b0;
      w_eat      = 1'b0;
      w_load_occ = 1'b0;
      case (r_state)
         IDLE: begin
            if (spawn_req) begin
               w_next  = SAMPLE;
               w_start = 1'b1;
            end
         end
         SAMPLE: begin
            w_load_occ = 1'b1;
            if (w_legal) begin
               w_next = CHECK;
            end else begin
               w_inc_try = 1'b1;
               if (w_try_last) begin
                  w_next = IDLE;
                  w_fail = 1'b1;
               end
            end
         end
         CHECK: begin
            // Query stays frozen until the body store answers.
            if (occ_ack) begin
               if (!occ_hit) begin
                  w_next  = PLACED;
                  w_place = 1'b1;
               end else begin
                  w_inc_try = 1'b1;
                  if (w_try_last) begin
                     w_next = IDLE;
                     w_fail = 1'b1;
                  end else begin
                     w_next = SAMPLE;
                  end
               end
            end
         end
         PLACED: begin
            w_eat = head_upd && (head_x == r_food_x) && (head_y == r_food_y);
            if (w_eat || spawn_req) begin
               w_next  = SAMPLE;
               w_start = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge VGA_clk) begin
      if (!rst_n) begin
         r_try        <= '0;
         r_occ_x      <= '0;
         r_occ_y      <= '0;
         r_food_x     <= '0;
         r_food_y     <= '0;
         r_food_valid <= 1'b0;
         r_eaten      <= 1'b0;
         r_fail       <= 1'b0;
      end else begin
         r_eaten <= w_eat;
         r_fail  <= w_fail;
         if (w_start)        r_try <= '0;
         else if (w_inc_try) r_try <= w_try_nxt;
         if (w_load_occ) begin
            r_occ_x <= randX;
            r_occ_y <= randY;
         end
         if (w_place) begin
            r_food_x     <= r_occ_x;
            r_food_y     <= r_occ_y;
            r_food_valid <= 1'b1;
         end else if (w_start) begin
            r_food_valid <= 1'b0;
         end
      end
   end

`ifdef FOOD_SCORE_EN
   logic [7:0] r_score;

   always_ff @(posedge VGA_clk) begin
      if (!rst_n)                          r_score <= '0;
      else if (r_eaten && r_score != 8'hFF) r_score <= r_score + 8'd1;
   end

   assign score = r_score;
`endif

   assign occ_req    = (r_state == CHECK);
   assign busy       = (r_state == SAMPLE) || (r_state == CHECK);
   assign occ_x      = r_occ_x;
   assign occ_y      = r_occ_y;
   assign food_x     = r_food_x;
   assign food_y     = r_food_y;
   assign food_valid = r_food_valid;
   assign eaten      = r_eaten;
   assign spawn_fail = r_fail;

endmodule

// File: tb/tb_food_spawner.sv
// Randomized self-checking bench for food_spawner against a rule-level spawn model.
module tb_food_spawner;

   localparam int MAXT = 8;

   logic       VGA_clk = 1'b0;
   logic       rst_n;
   logic [9:0] randX;
   logic [8:0] randY;
   logic       spawn_req;
   logic [9:0] head_x;
   logic [8:0] head_y;
   logic       head_upd;
   logic       occ_req;
   logic [9:0] occ_x;
   logic [8:0] occ_y;
   logic       occ_ack;
   logic       occ_hit;
   logic [9:0] food_x;
   logic [8:0] food_y;
   logic       food_valid;
   logic       eaten;
   logic       spawn_fail;
   logic       busy;
`ifdef FOOD_SCORE_EN
   logic [7:0] score;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int m_fx = 0;
   int m_fy = 0;
   bit m_fv = 0;
   int m_eats = 0;
   int bx [5] = '{0, 5, 615, 630, 1020};
   int by [5] = '{0, 5, 455, 470, 510};

   food_spawner #(.MAX_TRIES(MAXT)) dut (
      .VGA_clk(VGA_clk), .rst_n(rst_n), .randX(randX), .randY(randY),
      .spawn_req(spawn_req), .head_x(head_x), .head_y(head_y), .head_upd(head_upd),
      .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
      .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .eaten(eaten), .spawn_fail(spawn_fail), .busy(busy)
`ifdef FOOD_SCORE_EN
      , .score(score)
`endif
   );

   always #5 VGA_clk = ~VGA_clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge VGA_clk);
      #1;
   endtask

   function automatic bit ref_legal(input int x, input int y);
      return (x >= 10) && (x <= 620) && (y >= 10) && (y <= 460) && (x % 10 == 0) && (y % 10 == 0);
   endfunction

   // Inputs that must have no effect while a spawn is in progress.
   task automatic junk();
      spawn_req = 1'($urandom_range(0, 1));
      head_upd  = 1'($urandom_range(0, 1));
      head_x    = 10'(m_fx);
      head_y    = 9'(m_fy);
      occ_ack   = 1'($urandom_range(0, 1));
      occ_hit   = 1'($urandom_range(0, 1));
   endtask

   task automatic pick_cand(input int p_legal, output int cx, output int cy);
      if (int'($urandom_range(0, 99)) < p_legal) begin
         cx = 10 * int'($urandom_range(1, 62));
         cy = 10 * int'($urandom_range(1, 46));
      end else begin
         case ($urandom_range(0, 2))
            0: begin cx = int'($urandom_range(0, 1023)); cy = int'($urandom_range(0, 511)); end
            1: begin cx = bx[$urandom_range(0, 4)]; cy = 10 * int'($urandom_range(1, 46)); end
            default: begin cx = 10 * int'($urandom_range(1, 62)); cy = by[$urandom_range(0, 4)]; end
         endcase
      end
   endtask

   // Called with the DUT freshly in SAMPLE; follows one spawn to placement or failure.
   task automatic run_spawn(input int p_legal, input int p_hit);
      int tries, cx, cy, d;
      bit done, hit;
      tries = 0;
      done  = 0;
      while (!done) begin
         pick_cand(p_legal, cx, cy);
         randX = 10'(cx);
         randY = 9'(cy);
         junk();
         tick();
         chk("eaten_low", eaten, 0);
         chk("fv_low", food_valid, 0);
         if (ref_legal(cx, cy)) begin
            chk("occ_req_up", occ_req, 1);
            chk("occ_x", occ_x, cx);
            chk("occ_y", occ_y, cy);
            chk("busy_check", busy, 1);
            d = int'($urandom_range(0, 2));
            for (int k = 0; k < d; k++) begin
               junk();
               occ_ack = 1'b0;
               randX   = 10'($urandom_range(0, 1023));
               randY   = 9'($urandom_range(0, 511));
               tick();
               chk("occ_req_hold", occ_req, 1);
               chk("occ_x_hold", occ_x, cx);
               chk("occ_y_hold", occ_y, cy);
            end
            junk();
            hit     = (int'($urandom_range(0, 99)) < p_hit);
            occ_ack = 1'b1;
            occ_hit = hit;
            tick();
            chk("occ_req_drop", occ_req, 0);
            if (!hit) begin
               m_fx = cx;
               m_fy = cy;
               m_fv = 1;
               chk("fv_placed", food_valid, 1);
               chk("food_x", food_x, cx);
               chk("food_y", food_y, cy);
               chk("busy_placed", busy, 0);
               chk("fail_placed", spawn_fail, 0);
               done = 1;
            end else begin
               tries++;
            end
         end else begin
            chk("occ_req_low", occ_req, 0);
            tries++;
         end
         if (!done) begin
            if (tries == MAXT) begin
               chk("fail_pulse", spawn_fail, 1);
               chk("busy_fail", busy, 0);
               chk("fv_fail", food_valid, 0);
               m_fv      = 0;
               done      = 1;
               spawn_req = 1'b0;
               head_upd  = 1'b0;
               occ_ack   = 1'($urandom_range(0, 1));
               occ_hit   = 1'b0;
               tick();
               chk("fail_one_cycle", spawn_fail, 0);
               chk("busy_idle", busy, 0);
               chk("fv_idle", food_valid, 0);
            end else begin
               chk("fail_none", spawn_fail, 0);
               chk("busy_retry", busy, 1);
            end
         end
      end
      spawn_req = 1'b0;
      head_upd  = 1'b0;
      occ_ack   = 1'b0;
   endtask

   task automatic place_at(input int x, input int y);
      spawn_req = 1'b1;
      randX     = 10'(x);
      randY     = 9'(y);
      occ_ack   = 1'b0;
      occ_hit   = 1'b0;
      tick();
      spawn_req = 1'b0;
      tick();
      chk("pl_occ_req", occ_req, 1);
      occ_ack = 1'b1;
      tick();
      occ_ack = 1'b0;
      chk("pl_fv", food_valid, 1);
      chk("pl_fx", food_x, x);
      chk("pl_fy", food_y, y);
      m_fx = x;
      m_fy = y;
      m_fv = 1;
   endtask

   initial begin
      int act;
      rst_n = 1'b0; randX = '0; randY = '0; spawn_req = 1'b0; head_x = '0; head_y = '0;
      head_upd = 1'b0; occ_ack = 1'b0; occ_hit = 1'b0;
      tick();
      tick();
      chk("rst_fv", food_valid, 0);
      chk("rst_occ_req", occ_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_eaten", eaten, 0);
      chk("rst_fail", spawn_fail, 0);
      chk("rst_food_x", food_x, 0);
      chk("rst_occ_x", occ_x, 0);
      rst_n = 1'b1;

      // Minimum latency with ack held high from the start (ignored until CHECK).
      spawn_req = 1'b1; randX = 10'd100; randY = 9'd200; occ_ack = 1'b1; occ_hit = 1'b0;
      tick();
      spawn_req = 1'b0;
      chk("lat_e1_busy", busy, 1);
      chk("lat_e1_fv", food_valid, 0);
      chk("lat_e1_req", occ_req, 0);
      tick();
      chk("lat_e2_req", occ_req, 1);
      chk("lat_e2_fv", food_valid, 0);
      tick();
      chk("lat_e3_fv", food_valid, 1);
      chk("lat_e3_fx", food_x, 100);
      chk("lat_e3_fy", food_y, 200);
      chk("lat_e3_req", occ_req, 0);
      occ_ack = 1'b0;
      m_fx = 100; m_fy = 200; m_fv = 1;

      // Off-grid X for every try exhausts the budget.
      spawn_req = 1'b1; randX = 10'd105; randY = 9'd200;
      tick();
      spawn_req = 1'b0;
      chk("exh_fv_clr", food_valid, 0);
      for (int i = 0; i < MAXT; i++) begin
         tick();
         chk("exh_no_req", occ_req, 0);
         chk("exh_fail", spawn_fail, (i == MAXT - 1) ? 1 : 0);
         chk("exh_busy", busy, (i == MAXT - 1) ? 0 : 1);
      end
      occ_ack = 1'b1;
      tick();
      occ_ack = 1'b0;
      chk("exh_fail_drop", spawn_fail, 0);
      chk("exh_fv", food_valid, 0);
      chk("exh_late_ack_req", occ_req, 0);
      m_fv = 0;

      // Occupied first sample, free second sample.
      spawn_req = 1'b1; randX = 10'd50; randY = 9'd50;
      tick();
      spawn_req = 1'b0;
      tick();
      chk("hit_req", occ_req, 1);
      occ_ack = 1'b1; occ_hit = 1'b1; randX = 10'd60; randY = 9'd70;
      tick();
      chk("hit_back_busy", busy, 1);
      chk("hit_back_req", occ_req, 0);
      chk("hit_occ_x_kept", occ_x, 50);
      occ_ack = 1'b0; occ_hit = 1'b0;
      tick();
      chk("hit2_req", occ_req, 1);
      chk("hit2_occ_y", occ_y, 70);
      occ_ack = 1'b1;
      tick();
      occ_ack = 1'b0;
      chk("hit2_fx", food_x, 60);
      chk("hit2_fy", food_y, 70);
      chk("hit2_fv", food_valid, 1);
      m_fx = 60; m_fy = 70; m_fv = 1;

      // Near miss then exact hit on food at (300,300).
      place_at(300, 300);
      head_upd = 1'b1; head_x = 10'd300; head_y = 9'd310;
      tick();
      chk("miss_eaten", eaten, 0);
      chk("miss_fv", food_valid, 1);
      head_y = 9'd300;
      tick();
      head_upd = 1'b0;
      chk("eat_pulse", eaten, 1);
      chk("eat_fv", food_valid, 0);
      chk("eat_busy", busy, 1);
      m_fv = 0;
      m_eats++;
      run_spawn(70, 30);

      // Reset in the middle of a query, then a stale ack.
      place_at(200, 200);
      spawn_req = 1'b1; randX = 10'd400; randY = 9'd400;
      tick();
      spawn_req = 1'b0;
      tick();
      chk("rq_req", occ_req, 1);
      rst_n = 1'b0;
      tick();
      chk("rq_req_drop", occ_req, 0);
      chk("rq_busy", busy, 0);
      chk("rq_food_x", food_x, 0);
      rst_n = 1'b1; occ_ack = 1'b1; occ_hit = 1'b0;
      tick();
      occ_ack = 1'b0;
      chk("rq_late_fv", food_valid, 0);
      chk("rq_late_busy", busy, 0);
      tick();
      chk("rq_no_eat", eaten, 0);
      chk("rq_no_fail", spawn_fail, 0);
      m_fx = 0; m_fy = 0; m_fv = 0;

      for (int t = 0; t < 40; t++) begin
         act = m_fv ? int'($urandom_range(0, 3)) : 0;
         head_x = 10'(m_fx);
         head_y = 9'(m_fy);
         if (act == 3) begin
            head_upd = 1'b1;
            head_x   = 10'(m_fx + 10);
            tick();
            chk("rnd_miss_eaten", eaten, 0);
            chk("rnd_miss_fv", food_valid, 1);
            chk("rnd_miss_busy", busy, 0);
            act = 0;
         end
         spawn_req = (act == 0 || act == 2);
         head_upd  = (act == 1 || act == 2);
         head_x    = 10'(m_fx);
         tick();
         spawn_req = 1'b0;
         head_upd  = 1'b0;
         chk("rnd_start_busy", busy, 1);
         chk("rnd_start_fv", food_valid, 0);
         chk("rnd_start_eaten", eaten, (act == 1 || act == 2) ? 1 : 0);
         if (act != 0) m_eats++;
         m_fv = 0;
         run_spawn(int'($urandom_range(20, 90)), int'($urandom_range(0, 60)));
         occ_ack = 1'($urandom_range(0, 1));
         occ_hit = 1'b0;
         tick();
         occ_ack = 1'b0;
         chk("rnd_idle_fv", food_valid, m_fv ? 1 : 0);
         chk("rnd_idle_busy", busy, 0);
         chk("rnd_idle_eaten", eaten, 0);
      end

`ifdef FOOD_SCORE_EN
      chk("score", score, (m_eats > 255) ? 255 : m_eats);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
